clk_gen_prog: RTL and testbench

Programmable, glitch-free clock generator. It derives a registered output clock from `clk` with independently programmable high and low phase lengths, counted in `clk` cycles. It is the source side of our clock-measurement flow: it produces the divided/buffered clocks that our period and frequency benches capture on successive rising edges. Configuration changes take effect only at period boundaries, so `clk_out` never glitches or shows a truncated phase.

---
 rtl/clk_gen_prog.sv | 75 +++++++
 tb/tb_clk_gen_prog.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_prog.sv
// clk_gen_prog: glitch-free programmable clock with per-phase lengths applied at period boundaries
module clk_gen_prog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] hi_cnt,
  input  logic [CNT_W-1:0] lo_cnt,
  input  logic             load,
  output logic             cfg_ack,
  output logic             clk_out,
  output logic             rise_pls,
  output logic             fall_pls,
  output logic             running
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t           state;
  logic [CNT_W-1:0] act_hi, act_lo, pend_hi, pend_lo, cnt, hi_new;
  logic             pend_vld, last, apply;
  assign last    = cnt == '0;
  assign apply   = pend_vld && (state == IDLE || (state == LOW && last && en));
  assign hi_new  = apply ? pend_hi : act_hi;
  assign running = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clk_out  <= 1'b0;
      cnt      <= '0;
      act_hi   <= CNT_W'(1);
      act_lo   <= CNT_W'(1);
      pend_hi  <= CNT_W'(1);
      pend_lo  <= CNT_W'(1);
      pend_vld <= 1'b0;
      cfg_ack  <= 1'b0;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
    end else begin
      cfg_ack  <= apply;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
      // a load coinciding with an apply stays pending; the apply uses the older value
      if (load) begin
        pend_hi  <= hi_cnt == '0 ? CNT_W'(1) : hi_cnt;
        pend_lo  <= lo_cnt == '0 ? CNT_W'(1) : lo_cnt;
        pend_vld <= 1'b1;
      end else if (apply) pend_vld <= 1'b0;
      if (apply) begin
        act_hi <= pend_hi;
        act_lo <= pend_lo;
      end
      case (state)
        IDLE: begin
          clk_out <= en;
          rise_pls <= en;
          cnt <= en ? hi_new - 1'b1 : '0;
          state <= en ? HIGH : IDLE;
        end
        HIGH: begin
          cnt <= last ? act_lo - 1'b1 : cnt - 1'b1;
          clk_out <= !last;
          fall_pls <= last;
          state <= last ? LOW : HIGH;
        end
        LOW: begin
          cnt <= !last ? cnt - 1'b1 : (en ? hi_new - 1'b1 : '0);
          clk_out <= last && en;
          rise_pls <= last && en;
          state <= !last ? LOW : (en ? HIGH : IDLE);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_gen_prog.sv
// tb_clk_gen_prog: directed scenario tests for clk_gen_prog with hand-computed phase lengths
module tb_clk_gen_prog;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, load = 1'b0;
  logic [7:0] hi_cnt = '0, lo_cnt = '0;
  logic       cfg_ack, clk_out, rise_pls, fall_pls, running;
  int         pass_cnt = 0, tot = 0;

  clk_gen_prog #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .hi_cnt(hi_cnt), .lo_cnt(lo_cnt), .load(load),
    .cfg_ack(cfg_ack), .clk_out(clk_out), .rise_pls(rise_pls), .fall_pls(fall_pls),
    .running(running)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] l);
    hi_cnt = h;
    lo_cnt = l;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // waits for a rise, then counts the high and low cycles up to the next rise; -1 on timeout
  task automatic measure(output int hi_c, output int lo_c);
    int n = 0;
    while (!rise_pls && n < 600) begin tick(); n++; end
    if (!rise_pls) begin hi_c = -1; lo_c = -1; return; end
    hi_c = 0;
    while (clk_out && hi_c < 600) begin hi_c++; tick(); end
    lo_c = 0;
    while (!clk_out && lo_c < 600) begin lo_c++; tick(); end
  endtask

  task automatic wait_idle();
    int n = 0;
    en = 1'b0;
    while (running && n < 600) begin tick(); n++; end
    tot++;
    if (running !== 1'b0) $display("FAIL wait_idle: running=%b required 0", running);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tot += 5;
    if (clk_out !== 1'b0) $display("FAIL reset_clk_out: got %b required 0", clk_out); else pass_cnt++;
    if (running !== 1'b0) $display("FAIL reset_running: got %b required 0", running); else pass_cnt++;
    if (cfg_ack !== 1'b0) $display("FAIL reset_cfg_ack: got %b required 0", cfg_ack); else pass_cnt++;
    if (rise_pls !== 1'b0) $display("FAIL reset_rise: got %b required 0", rise_pls); else pass_cnt++;
    if (fall_pls !== 1'b0) $display("FAIL reset_fall: got %b required 0", fall_pls); else pass_cnt++;
  endtask

  task automatic test_basic();
    int h, l;
    time t0;
    do_load(8'd2, 8'd3);
    en = 1'b1;
    measure(h, l);
    t0 = $time;
    measure(h, l);
    tot += 4;
    if (h * 20 !== 40) $display("FAIL basic_high: got %0d units required 40", h * 20); else pass_cnt++;
    if (l * 20 !== 60) $display("FAIL basic_low: got %0d units required 60", l * 20); else pass_cnt++;
    if ($time - t0 !== 100) $display("FAIL basic_period: got %0t required 100", $time - t0); else pass_cnt++;
    if (running !== 1'b1) $display("FAIL basic_running: got %b required 1", running); else pass_cnt++;
    wait_idle();
  endtask

  task automatic test_idle_apply();
    int h, l;
    do_load(8'd1, 8'd1);
    tot += 3;
    if (cfg_ack !== 1'b0) $display("FAIL idle_ack_early: got %b required 0", cfg_ack); else pass_cnt++;
    tick();
    if (cfg_ack !== 1'b1) $display("FAIL idle_ack: got %b required 1", cfg_ack); else pass_cnt++;
    tick();
    if (cfg_ack !== 1'b0) $display("FAIL idle_ack_width: got %b required 0", cfg_ack); else pass_cnt++;
    en = 1'b1;
    measure(h, l);
    tot++;
    if ((h + l) * 20 !== 40) $display("FAIL idle_period: got %0d units required 40", (h + l) * 20); else pass_cnt++;
    wait_idle();
  endtask

  task automatic test_deferred();
    int h, l, n;
    logic early = 1'b0;
    do_load(8'd4, 8'd4);
    en = 1'b1;
    measure(h, l);
    tot += 2;
    if (h !== 4) $display("FAIL defer_first_high: got %0d required 4", h); else pass_cnt++;
    if (l !== 4) $display("FAIL defer_first_low: got %0d required 4", l); else pass_cnt++;
    tick();
    do_load(8'd1, 8'd1);
    n = 2;
    while (!rise_pls && n < 600) begin early |= cfg_ack; tick(); n++; end
    tot += 3;
    if (n !== 8) $display("FAIL defer_period: got %0d cycles required 8", n); else pass_cnt++;
    if (early !== 1'b0) $display("FAIL defer_ack_early: got %b required 0", early); else pass_cnt++;
    if (cfg_ack !== 1'b1) $display("FAIL defer_ack_at_rise: got %b required 1", cfg_ack); else pass_cnt++;
    measure(h, l);
    tot++;
    if (h + l !== 2) $display("FAIL defer_new_period: got %0d required 2", h + l); else pass_cnt++;
  endtask

  task automatic test_stop();
    int n = 0, lo_run = 0;
    logic bad = 1'b0;
    do_load(8'd3, 8'd3);
    while (!cfg_ack && n < 600) begin tick(); n++; end
    tick();
    en = 1'b0;
    n = 0;
    while (clk_out && n < 600) begin tick(); n++; end
    while (running && !clk_out && lo_run < 50) begin lo_run++; tick(); end
    tot += 3;
    if (n !== 2) $display("FAIL stop_high_rest: got %0d required 2", n); else pass_cnt++;
    if (lo_run !== 3) $display("FAIL stop_low: got %0d required 3", lo_run); else pass_cnt++;
    if (running !== 1'b0) $display("FAIL stop_running: got %b required 0", running); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin bad |= clk_out | running | rise_pls; tick(); end
    tot++;
    if (bad !== 1'b0) $display("FAIL stop_rest: activity=%b required 0", bad); else pass_cnt++;
  endtask

  task automatic test_zero();
    int h, l;
    do_load(8'd0, 8'd0);
    tick();
    tot++;
    if (cfg_ack !== 1'b1) $display("FAIL zero_ack: got %b required 1", cfg_ack); else pass_cnt++;
    en = 1'b1;
    measure(h, l);
    tot += 2;
    if (h !== 1) $display("FAIL zero_high: got %0d required 1", h); else pass_cnt++;
    if (l !== 1) $display("FAIL zero_low: got %0d required 1", l); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int h, l, n = 0;
    do_load(8'd4, 8'd4);
    while (!cfg_ack && n < 600) begin tick(); n++; end
    do_load(8'd2, 8'd2);
    rst = 1'b1;
    en = 1'b0;
    tick();
    rst = 1'b0;
    tot += 3;
    if (clk_out !== 1'b0) $display("FAIL rmid_clk_out: got %b required 0", clk_out); else pass_cnt++;
    if (running !== 1'b0) $display("FAIL rmid_running: got %b required 0", running); else pass_cnt++;
    if (cfg_ack !== 1'b0) $display("FAIL rmid_ack: got %b required 0", cfg_ack); else pass_cnt++;
    tick();
    tot++;
    if (cfg_ack !== 1'b0) $display("FAIL rmid_stale_ack: got %b required 0", cfg_ack); else pass_cnt++;
    en = 1'b1;
    measure(h, l);
    tot += 2;
    if (h !== 1) $display("FAIL rmid_high: got %0d required 1", h); else pass_cnt++;
    if (l !== 1) $display("FAIL rmid_low: got %0d required 1", l); else pass_cnt++;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_idle_apply();
    test_deferred();
    test_stop();
    test_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
